// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit:
// FSM states, instruction formats, branch conditions and IR field positions.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALT    = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_B = 2'b10,
        FMT_H = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_Z  = 2'b01,
        COND_C  = 2'b10,
        COND_NZ = 2'b11
    } cond_e;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;
    localparam logic [1:0] CLS_BAD   = 2'b11;

    localparam int FMT_HI  = 15;
    localparam int FMT_LO  = 14;
    localparam int R_OP_HI = 13;
    localparam int R_OP_LO = 10;
    localparam int R_RD_HI = 9;
    localparam int R_RD_LO = 7;
    localparam int R_RS_HI = 6;
    localparam int R_RS_LO = 4;
    localparam int R_RT_HI = 3;
    localparam int R_RT_LO = 1;
    localparam int I_RD_HI = 13;
    localparam int I_RD_LO = 11;
    localparam int I_CLS   = 10;
    localparam int I_OP_HI = 9;
    localparam int I_OP_LO = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    localparam int B_CC_HI = 13;
    localparam int B_CC_LO = 12;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] count;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [7:0] imm;
        logic       op2_sel;
        logic       is_branch;
        cond_e      cond;
        logic       illegal;
        logic       halt;
    } dec_t;

    function automatic logic branch_taken(cond_e cond, logic z, logic c);
        logic t;
        case (cond)
            COND_AL: t = 1'b1;
            COND_Z:  t = z;
            COND_C:  t = c;
            default: t = ~z;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational split of the 16-bit instruction register into control fields,
// including illegal-opcode and halt detection.
module cpu_instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] ir_i,
    output dec_t        dec_o
);

    fmt_e fmt;
    assign fmt = fmt_e'(ir_i[FMT_HI:FMT_LO]);

    always_comb begin
        dec_o = '0;
        case (fmt)
            FMT_R: begin
                dec_o.alu_op = ir_i[R_OP_HI:R_OP_LO];
                dec_o.rd     = ir_i[R_RD_HI:R_RD_LO];
                dec_o.rs     = ir_i[R_RS_HI:R_RS_LO];
                dec_o.rt     = ir_i[R_RT_HI:R_RT_LO];
                if (ir_i[R_OP_HI -: 2] == CLS_SHIFT)
                    dec_o.count = ir_i[R_RT_HI:R_RT_LO];
                dec_o.illegal = (ir_i[R_OP_HI -: 2] == CLS_BAD);
            end
            FMT_I: begin
                dec_o.alu_op  = {1'b0, ir_i[I_CLS], ir_i[I_OP_HI:I_OP_LO]};
                dec_o.rd      = ir_i[I_RD_HI:I_RD_LO];
                dec_o.rs      = ir_i[I_RD_HI:I_RD_LO];
                dec_o.imm     = ir_i[IMM_HI:IMM_LO];
                dec_o.op2_sel = 1'b1;
            end
            FMT_B: begin
                dec_o.is_branch = 1'b1;
                dec_o.cond      = cond_e'(ir_i[B_CC_HI:B_CC_LO]);
                // Branch target travels in the immediate field.
                dec_o.imm       = ir_i[IMM_HI:IMM_LO];
            end
            default: dec_o.halt = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit with PC sequencing and Z/C flags.
// Optional single-step gating of fetches via `CPU_CTRL_SINGLE_STEP_EN.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic            step_i,
`endif
    output logic            instr_req_o,
    output logic [PC_W-1:0] pc_o,
    input  logic [15:0]     instr_i,
    input  logic            instr_valid_i,
    output logic [3:0]      alu_op_o,
    output logic [2:0]      count_o,
    output logic            carry_o,
    output logic [2:0]      rs_addr_o,
    output logic [2:0]      rt_addr_o,
    output logic [2:0]      rd_addr_o,
    output logic [7:0]      imm_o,
    output logic            op2_sel_o,
    output logic            reg_we_o,
    input  logic            alu_zero_i,
    input  logic            alu_carry_i,
    output logic            zero_flag_o,
    output logic            carry_flag_o,
    output logic            halted_o,
    output logic            illegal_o
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    dec_t            dec_q, dec_d, dec;
    logic            z_q, z_d, c_q, c_d;
    // arm_q holds fetch requests low for the first cycle after reset and,
    // in single-step builds, until a step is granted.
    logic            arm_q, arm_d;
    logic            fetch_ack;

    cpu_instr_decoder u_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign instr_req_o = (state_q == S_FETCH) && arm_q;
    assign fetch_ack   = instr_req_o && instr_valid_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dec_d   = dec_q;
        z_d     = z_q;
        c_d     = c_q;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        arm_d   = arm_q;
        if (state_q == S_FETCH) begin
            if (fetch_ack)
                arm_d = 1'b0;
            else if (!arm_q && step_i)
                arm_d = 1'b1;
        end
`else
        arm_d   = 1'b1;
`endif
        case (state_q)
            S_FETCH: begin
                if (fetch_ack) begin
                    ir_d    = instr_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_d   = dec;
                state_d = (dec.illegal || dec.halt) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                if (dec_q.is_branch) begin
                    // Condition uses flags from before this instruction.
                    pc_d = branch_taken(dec_q.cond, z_q, c_q) ? PC_W'(dec_q.imm)
                                                             : pc_q + PC_W'(1);
                end else begin
                    z_d  = alu_zero_i;
                    c_d  = alu_carry_i;
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            dec_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dec_q   <= dec_d;
            z_q     <= z_d;
            c_q     <= c_d;
            arm_q   <= arm_d;
        end
    end

    assign pc_o         = pc_q;
    assign alu_op_o     = dec_q.alu_op;
    assign count_o      = dec_q.count;
    assign rs_addr_o    = dec_q.rs;
    assign rt_addr_o    = dec_q.rt;
    assign rd_addr_o    = dec_q.rd;
    assign imm_o        = dec_q.imm;
    assign op2_sel_o    = dec_q.op2_sel;
    assign carry_o      = c_q;
    assign zero_flag_o  = z_q;
    assign carry_flag_o = c_q;
    assign reg_we_o     = (state_q == S_EXECUTE) && !dec_q.is_branch;
    assign halted_o     = (state_q == S_HALT);
    assign illegal_o    = dec_q.illegal;

    logic unused_dec;
    assign unused_dec = dec_q.halt;

endmodule
